npu_out_writer: RTL and testbench
=================================

# npu_out_writer

Downstream stage of the NPU core. It collects the 8-bit quantized result stream (core output enable and byte), packs bytes little-endian into 32-bit words, and writes them to the output buffer RAM through a ready/valid write port. A small word FIFO absorbs RAM back-pressure, because the core cannot stall. The block also folds the core's per-sample range values into job-level max/min statistics for software requantization calibration.

## Interface
- FIFO_DEPTH, 4: word FIFO entries (power of 2, ≥2)
- ADDR_W, 16: word address width
- CLK  in  1  single clock, rising edge
- RESET_X  in  1  asynchronous, active-low reset
- SOFT_RESET  in  1  active-high; internal reset = RESET_X & ~SOFT_RESET, applied asynchronously
- START  in  1  one-cycle job start pulse; ignored while BUSY
- BASE_ADDR  in  ADDR_W  first word address; sampled on START
- LENGTH  in  16  job length in bytes; sampled on START
- IN_EN  in  1  result byte valid (from core OUTPUT_EN)
- IN_DATA  in  8  result byte (from core C_OUT)
- RMAX_IN  in  16  signed per-sample max (from core RMAX); sampled with IN_EN
- RMIN_IN  in  16  signed per-sample min (from core RMIN); sampled with IN_EN
- WR_EN  out  1  write request (valid)
- WR_READY  in  1  RAM accepts write
- WR_ADDR  out  ADDR_W  word address
- WR_DATA  out  32  packed word
- WR_BE  out  4  byte enables; bit i covers WR_DATA[8i+7:8i]
- BUSY  out  1  job in progress
- DONE  out  1  one-cycle completion pulse
- BYTE_CNT  out  16  bytes accepted in the current job
- OVERFLOW  out  1  sticky: a word was dropped because the FIFO was full
- STAT_MAX  out  16  signed running max of RMAX_IN
- STAT_MIN  out  16  signed running min of RMIN_IN

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE -> RUN on START with LENGTH≠0. START also:
  - latches BASE_ADDR and LENGTH;
  - clears BYTE_CNT, the pack lane, and OVERFLOW;
  - loads STAT_MAX=16'h8000 and STAT_MIN=16'h7FFF.
- START with LENGTH=0: stay in IDLE; DONE pulses the next cycle.
- RUN: each IN_EN byte goes into lane BYTE_CNT[1:0], and BYTE_CNT increments.
  - On lane 3, or on the last byte (BYTE_CNT+1==LENGTH), the word plus its BE mask is pushed to the FIFO.
  - Unused lanes of a partial word carry data 0 and BE 0.
  - The push address is BASE_ADDR + word index, modulo 2^ADDR_W (wraps).
- RUN -> FLUSH on acceptance of the last byte.
- FLUSH -> IDLE when the FIFO is empty and no write is outstanding. DONE pulses on that transition.
- IN_EN in IDLE or FLUSH: byte ignored; BYTE_CNT and stats unchanged.
- Stats: on each accepted byte, STAT_MAX = signed max(STAT_MAX, RMAX_IN) and STAT_MIN = signed min(STAT_MIN, RMIN_IN). Values are held after DONE until the next START.
- Write port: WR_EN = FIFO not empty. WR_ADDR/WR_DATA/WR_BE = FIFO head, stable while WR_EN & ~WR_READY. A transfer occurs on WR_EN & WR_READY.
- FIFO full with a push and no pop in the same cycle: word dropped, OVERFLOW←1, and the byte count still advances. Push and pop in the same cycle while full is legal; nothing is dropped.
- BUSY = (state≠IDLE).

## Timing
- Reset values: WR_EN 0, WR_ADDR 0, WR_DATA 0, WR_BE 0, BUSY 0, DONE 0, BYTE_CNT 0, OVERFLOW 0, STAT_MAX 0, STAT_MIN 0; state IDLE; FIFO empty.
- BUSY rises the cycle after START.
- Latency: a word is pushed at the edge that samples its closing byte, and WR_EN is high the following cycle, so the first write is 1 cycle after the closing IN_EN edge.
- Core throughput is 1 byte per cycle, i.e. 1 word every 4 cycles. With WR_READY held high the FIFO never exceeds 1 entry.
- DONE is high for exactly one cycle, the cycle after the final write handshake. BUSY is low in that same cycle.
- START in the DONE cycle is accepted.
- Reset mid-job (either source) returns to IDLE immediately and discards FIFO contents. No DONE is generated.

## Structure
- Shared package npu_pkg holds:
  - the state encoding (IDLE/RUN/FLUSH);
  - byte-lane and word widths;
  - stat init constants 16'h8000 and 16'h7FFF.
- Sub-module npu_wfifo is a synchronous FIFO (FIFO_DEPTH × {ADDR_W addr, 32 data, 4 BE}) with full/empty flags and an async active-low reset. The packer, FSM, and stats stay in the top level.

## Test plan
- LENGTH=8, BASE_ADDR=0x0010, bytes 0x01..0x08 back-to-back, WR_READY=1 -> writes {0x0010, 0x04030201, BE F} and {0x0011, 0x08070605, BE F}; DONE one cycle after the second write; BYTE_CNT=8.
- LENGTH=6, bytes 0xA0..0xA5 -> second write is data 0x0000A5A4 with BE 0x3.
- LENGTH=16, WR_READY=0 for 20 cycles -> 4 words queued, no drop, OVERFLOW=0. With WR_READY=0 held through the end of the job, LENGTH=20 -> the fifth word is dropped and OVERFLOW=1.
- BASE_ADDR=0xFFFF, LENGTH=8 -> WR_ADDR sequence 0xFFFF, 0x0000.
- RMAX_IN values {5, -3, 100}, RMIN_IN values {-7, 2, -200} with LENGTH=3 -> STAT_MAX=100 (0x0064), STAT_MIN=-200 (0xFF38); LENGTH=0 START -> DONE next cycle, no write.
- SOFT_RESET pulse mid-job after 5 bytes -> BUSY 0, WR_EN 0, BYTE_CNT 0, no DONE. A new START then runs cleanly.

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: definitions shared by the NPU output writer and its word FIFO.
// It holds the writer FSM state encoding, the byte-lane and word widths,
// and the reset values for the job-level range statistics.
package npu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } wr_state_t;

    localparam int LANE_W = 8;                // one quantized result byte
    localparam int WORD_W = 32;               // one output-buffer word
    localparam int BE_W   = WORD_W / LANE_W;  // byte enables per word

    // Statistics start at the opposite extremes so that the first sample wins.
    localparam logic signed [15:0] STAT_MAX_INIT = 16'sh8000;
    localparam logic signed [15:0] STAT_MIN_INIT = 16'sh7FFF;

endpackage

// File: rtl/npu_wfifo.sv
// npu_wfifo: synchronous word FIFO that sits between the byte packer and the
// output-buffer RAM write port. Each entry holds {address, data, byte enables}.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_push, i_addr/data/be  write side; the entry is dropped when full unless
//                           a pop happens in the same cycle
//   i_pop                   consume the head entry
//   o_addr/data/be          head entry (all zero while empty)
//   o_full, o_empty, o_count  occupancy flags and entry count
module npu_wfifo
    import npu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [WORD_W-1:0]       i_data,
    input  logic [BE_W-1:0]         i_be,
    input  logic                    i_pop,
    output logic [ADDR_W-1:0]       o_addr,
    output logic [WORD_W-1:0]       o_data,
    output logic [BE_W-1:0]         o_be,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [WORD_W-1:0] r_mem_data [DEPTH];
    logic [BE_W-1:0]   r_mem_be   [DEPTH];
    logic [PW:0]       r_wptr;
    logic [PW:0]       r_rptr;
    logic [PW:0]       w_count;
    logic              w_wr;
    logic              w_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count = r_wptr - r_rptr;
    assign o_count = w_count;
    assign o_full  = (w_count == (PW+1)'(DEPTH));
    assign o_empty = (w_count == '0);

    // A push while full is still legal when the head leaves in the same cycle.
    assign w_wr = i_push & (~o_full | i_pop);
    assign w_rd = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem_addr[r_wptr[PW-1:0]] <= i_addr;
            r_mem_data[r_wptr[PW-1:0]] <= i_data;
            r_mem_be[r_wptr[PW-1:0]]   <= i_be;
        end
    end

    // Head is masked while empty so the write port idles at all-zero.
    assign o_addr = o_empty ? '0 : r_mem_addr[r_rptr[PW-1:0]];
    assign o_data = o_empty ? '0 : r_mem_data[r_rptr[PW-1:0]];
    assign o_be   = o_empty ? '0 : r_mem_be[r_rptr[PW-1:0]];

endmodule

// File: rtl/npu_out_writer.sv
// npu_out_writer: collects the NPU core's quantized byte stream, packs it
// little-endian into 32-bit words, and writes them to the output buffer RAM
// through a ready/valid port buffered by a small word FIFO. It also tracks
// the job-level signed max/min of the per-sample range values.
// Ports:
//   CLK, RESET_X, SOFT_RESET     clock; async active-low reset; active-high soft reset
//   START, BASE_ADDR, LENGTH     job start pulse, first word address, length in bytes
//   IN_EN, IN_DATA               result byte stream from the core
//   RMAX_IN, RMIN_IN             signed per-sample range values, sampled with IN_EN
//   WR_EN/READY/ADDR/DATA/BE     output buffer write port
//   BUSY, DONE, BYTE_CNT         job status
//   OVERFLOW                     sticky word-drop flag
//   STAT_MAX, STAT_MIN           job-level range statistics
module npu_out_writer
    import npu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_X,
    input  logic                     SOFT_RESET,
    input  logic                     START,
    input  logic [ADDR_W-1:0]        BASE_ADDR,
    input  logic [15:0]              LENGTH,
    input  logic                     IN_EN,
    input  logic [LANE_W-1:0]        IN_DATA,
    input  logic signed [15:0]       RMAX_IN,
    input  logic signed [15:0]       RMIN_IN,
    output logic                     WR_EN,
    input  logic                     WR_READY,
    output logic [ADDR_W-1:0]        WR_ADDR,
    output logic [WORD_W-1:0]        WR_DATA,
    output logic [BE_W-1:0]          WR_BE,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [15:0]              BYTE_CNT,
    output logic                     OVERFLOW,
    output logic signed [15:0]       STAT_MAX,
    output logic signed [15:0]       STAT_MIN
);

    function automatic logic signed [15:0] f_smax(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [15:0] f_smin(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        return (a < b) ? a : b;
    endfunction

    wr_state_t                r_state;
    wr_state_t                w_state_nxt;
    logic                     w_done_nxt;
    logic                     r_done;
    logic [ADDR_W-1:0]        r_base;
    logic [15:0]              r_len;
    logic [15:0]              r_byte_cnt;
    logic [WORD_W-1:0]        r_pack_data;
    logic [BE_W-1:0]          r_pack_be;
    logic                     r_ovf;
    logic signed [15:0]       r_stat_max;
    logic signed [15:0]       r_stat_min;

    logic                     w_rst_n;
    logic                     w_start;
    logic                     w_accept;
    logic [1:0]               w_lane;
    logic                     w_last;
    logic                     w_push;
    logic [WORD_W-1:0]        w_word;
    logic [BE_W-1:0]          w_be;
    logic [ADDR_W-1:0]        w_push_addr;
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    // Soft reset acts exactly like the hard reset, asynchronously.
    assign w_rst_n = RESET_X & ~SOFT_RESET;

    assign w_start  = (r_state == ST_IDLE) & START;
    assign w_accept = (r_state == ST_RUN) & IN_EN;
    assign w_lane   = r_byte_cnt[1:0];
    assign w_last   = ((r_byte_cnt + 16'd1) == r_len);

    // The incoming byte is merged combinationally so a closing byte can be
    // pushed on the same edge that samples it.
    assign w_word      = r_pack_data | (WORD_W'(IN_DATA) << {w_lane, 3'b000});
    assign w_be        = r_pack_be | (BE_W'(1) << w_lane);
    assign w_push      = w_accept & ((w_lane == 2'd3) | w_last);
    assign w_push_addr = r_base + ADDR_W'(r_byte_cnt[15:2]);

    assign w_pop = WR_EN & WR_READY;

    npu_wfifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wfifo (
        .i_clk   (CLK),
        .i_rst_n (w_rst_n),
        .i_push  (w_push),
        .i_addr  (w_push_addr),
        .i_data  (w_word),
        .i_be    (w_be),
        .i_pop   (w_pop),
        .o_addr  (WR_ADDR),
        .o_data  (WR_DATA),
        .o_be    (WR_BE),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign WR_EN = ~w_fifo_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    if (LENGTH != 16'd0) w_state_nxt = ST_RUN;
                    else                 w_done_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_accept && w_last) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Leave as the last entry is handed over so DONE lands in the
                // cycle right after the final write handshake.
                if (w_fifo_empty || (w_fifo_count == 1 && w_pop)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_base      <= '0;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_pack_data <= '0;
            r_pack_be   <= '0;
            r_ovf       <= 1'b0;
            r_stat_max  <= '0;
            r_stat_min  <= '0;
        end else begin
            if (w_start) begin
                r_base      <= BASE_ADDR;
                r_len       <= LENGTH;
                r_byte_cnt  <= '0;
                r_pack_data <= '0;
                r_pack_be   <= '0;
                r_ovf       <= 1'b0;
                r_stat_max  <= STAT_MAX_INIT;
                r_stat_min  <= STAT_MIN_INIT;
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
                r_stat_max <= f_smax(r_stat_max, RMAX_IN);
                r_stat_min <= f_smin(r_stat_min, RMIN_IN);
                if (w_push) begin
                    r_pack_data <= '0;
                    r_pack_be   <= '0;
                    // Word is lost when no slot frees up this cycle.
                    if (w_fifo_full && !w_pop) r_ovf <= 1'b1;
                end else begin
                    r_pack_data <= w_word;
                    r_pack_be   <= w_be;
                end
            end
        end
    end

    assign BUSY     = (r_state != ST_IDLE);
    assign DONE     = r_done;
    assign BYTE_CNT = r_byte_cnt;
    assign OVERFLOW = r_ovf;
    assign STAT_MAX = r_stat_max;
    assign STAT_MIN = r_stat_min;

endmodule

// File: tb/tb_npu_out_writer.sv
module tb_npu_out_writer;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 16;

    logic               CLK = 1'b0;
    logic               RESET_X;
    logic               SOFT_RESET;
    logic               START;
    logic [15:0]        BASE_ADDR;
    logic [15:0]        LENGTH;
    logic               IN_EN;
    logic [7:0]         IN_DATA;
    logic signed [15:0] RMAX_IN;
    logic signed [15:0] RMIN_IN;
    logic               WR_EN;
    logic               WR_READY;
    logic [15:0]        WR_ADDR;
    logic [31:0]        WR_DATA;
    logic [3:0]         WR_BE;
    logic               BUSY;
    logic               DONE;
    logic [15:0]        BYTE_CNT;
    logic               OVERFLOW;
    logic signed [15:0] STAT_MAX;
    logic signed [15:0] STAT_MIN;

    always #5 CLK = ~CLK;

    npu_out_writer #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET_X(RESET_X), .SOFT_RESET(SOFT_RESET), .START(START),
        .BASE_ADDR(BASE_ADDR), .LENGTH(LENGTH), .IN_EN(IN_EN), .IN_DATA(IN_DATA),
        .RMAX_IN(RMAX_IN), .RMIN_IN(RMIN_IN), .WR_EN(WR_EN), .WR_READY(WR_READY),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_BE(WR_BE), .BUSY(BUSY),
        .DONE(DONE), .BYTE_CNT(BYTE_CNT), .OVERFLOW(OVERFLOW),
        .STAT_MAX(STAT_MAX), .STAT_MIN(STAT_MIN)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t                exp_q[$];
    wr_t                mon_e;
    int                 n_tests = 0;
    int                 n_fail  = 0;
    int                 cyc = 0;
    int                 last_hs_cyc = -100;
    int                 wr_cnt = 0;
    int                 done_cnt = 0;
    logic [7:0]         b_arr  [0:31];
    logic signed [15:0] mx_arr [0:31];
    logic signed [15:0] mn_arr [0:31];
    logic signed [15:0] exp_max;
    logic signed [15:0] exp_min;
    logic               exp_ovf;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Write-port scoreboard: every handshake pops one expected word.
    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if (WR_EN && WR_READY) begin
            wr_cnt++;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", 64'(WR_EN), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("wr_addr", 64'(WR_ADDR), 64'(mon_e.addr));
                check_val("wr_data", 64'(WR_DATA), 64'(mon_e.data));
                check_val("wr_be",   64'(WR_BE),   64'(mon_e.be));
            end
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0: b_arr[i] = 8'(i + 1);
                1: b_arr[i] = 8'(8'hA0 + i);
                default: b_arr[i] = 8'($urandom_range(0, 255));
            endcase
            mx_arr[i] = 16'($urandom_range(0, 200)) - 16'sd100;
            mn_arr[i] = 16'($urandom_range(0, 200)) - 16'sd100;
        end
    endtask

    // Start a job and stream all bytes, predicting every word and the stats.
    task automatic send_job(input logic [15:0] base, input logic [15:0] len);
        logic [31:0] word;
        logic [3:0]  be;
        wr_t         e;
        @(posedge CLK) #1;
        START = 1'b1; BASE_ADDR = base; LENGTH = len;
        @(negedge CLK);
        check_val("busy_before_start", 64'(BUSY), 64'd0);
        @(posedge CLK) #1;
        START = 1'b0;
        exp_max = 16'sh8000; exp_min = 16'sh7FFF; exp_ovf = 1'b0;
        word = '0; be = '0;
        @(negedge CLK);
        if (len != 0) check_val("busy_rise", 64'(BUSY), 64'd1);
        for (int i = 0; i < int'(len); i++) begin
            @(posedge CLK) #1;
            IN_EN = 1'b1; IN_DATA = b_arr[i]; RMAX_IN = mx_arr[i]; RMIN_IN = mn_arr[i];
            word = word | (32'(b_arr[i]) << (8 * (i % 4)));
            be   = be | (4'b0001 << (i % 4));
            if (mx_arr[i] > exp_max) exp_max = mx_arr[i];
            if (mn_arr[i] < exp_min) exp_min = mn_arr[i];
            if ((i % 4) == 3 || i == int'(len) - 1) begin
                if (!WR_READY && exp_q.size() >= FIFO_DEPTH) begin
                    exp_ovf = 1'b1;
                end else begin
                    e.addr = base + 16'(i / 4);
                    e.data = word;
                    e.be   = be;
                    exp_q.push_back(e);
                end
                word = '0; be = '0;
            end
        end
        // A stray byte after the last one must be ignored.
        @(posedge CLK) #1;
        IN_EN = 1'b1; IN_DATA = 8'hEE; RMAX_IN = 16'sh7000; RMIN_IN = 16'sh9000;
        @(posedge CLK) #1;
        IN_EN = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1;
                check_val("busy_low_at_done", 64'(BUSY), 64'd0);
                check_val("done_after_last_write", 64'(cyc - last_hs_cyc), 64'd1);
                @(negedge CLK);
                check_val("done_one_cycle", 64'(DONE), 64'd0);
            end
        end
        if (!seen) check_val("done_timeout", 64'(DONE), 64'd1);
    endtask

    task automatic job_end_checks(input logic [15:0] len);
        check_val("byte_cnt",   64'(BYTE_CNT), 64'(len));
        check_val("overflow",   64'(OVERFLOW), 64'(exp_ovf));
        check_val("stat_max",   64'($unsigned(STAT_MAX)), 64'($unsigned(exp_max)));
        check_val("stat_min",   64'($unsigned(STAT_MIN)), 64'($unsigned(exp_min)));
        check_val("all_writes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wr_snap;
        int done_snap;
        RESET_X = 1'b0; SOFT_RESET = 1'b0; START = 1'b0; BASE_ADDR = '0; LENGTH = '0;
        IN_EN = 1'b0; IN_DATA = '0; RMAX_IN = '0; RMIN_IN = '0; WR_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET_X = 1'b1;
        // Byte in IDLE must be ignored.
        IN_EN = 1'b1; IN_DATA = 8'h55; RMAX_IN = 16'sd9; RMIN_IN = 16'sd9;
        @(posedge CLK) #1 IN_EN = 1'b0;
        @(negedge CLK);
        check_val("rst_wr_en",    64'(WR_EN), 64'd0);
        check_val("rst_wr_addr",  64'(WR_ADDR), 64'd0);
        check_val("rst_wr_data",  64'(WR_DATA), 64'd0);
        check_val("rst_wr_be",    64'(WR_BE), 64'd0);
        check_val("rst_busy",     64'(BUSY), 64'd0);
        check_val("rst_done",     64'(DONE), 64'd0);
        check_val("rst_byte_cnt", 64'(BYTE_CNT), 64'd0);
        check_val("rst_overflow", 64'(OVERFLOW), 64'd0);
        check_val("rst_stat_max", 64'($unsigned(STAT_MAX)), 64'd0);
        check_val("rst_stat_min", 64'($unsigned(STAT_MIN)), 64'd0);

        // Two full words, bytes 0x01..0x08.
        fill(0);
        send_job(16'h0010, 16'd8);
        wait_done(100);
        job_end_checks(16'd8);

        // Partial last word.
        fill(1);
        send_job(16'h0200, 16'd6);
        wait_done(100);
        job_end_checks(16'd6);

        // Back-pressure: four words fit in the FIFO.
        fill(2);
        WR_READY = 1'b0;
        send_job(16'h0300, 16'd16);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_val("bp16_overflow", 64'(OVERFLOW), 64'd0);
        check_val("bp16_wr_en",    64'(WR_EN), 64'd1);
        @(posedge CLK) #1 WR_READY = 1'b1;
        wait_done(100);
        job_end_checks(16'd16);

        // Back-pressure through the job: fifth word dropped.
        fill(2);
        WR_READY = 1'b0;
        send_job(16'h0400, 16'd20);
        @(negedge CLK);
        check_val("bp20_overflow", 64'(OVERFLOW), 64'd1);
        check_val("bp20_busy",     64'(BUSY), 64'd1);
        @(posedge CLK) #1 WR_READY = 1'b1;
        wait_done(100);
        job_end_checks(16'd20);

        // Address wrap.
        fill(2);
        send_job(16'hFFFF, 16'd8);
        wait_done(100);
        job_end_checks(16'd8);

        // Statistics.
        fill(2);
        mx_arr[0] = 16'sd5;  mx_arr[1] = -16'sd3; mx_arr[2] = 16'sd100;
        mn_arr[0] = -16'sd7; mn_arr[1] = 16'sd2;  mn_arr[2] = -16'sd200;
        send_job(16'h0500, 16'd3);
        wait_done(100);
        job_end_checks(16'd3);
        check_val("stat_max_100",  64'($unsigned(STAT_MAX)), 64'h0064);
        check_val("stat_min_m200", 64'($unsigned(STAT_MIN)), 64'hFF38);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("stat_max_held", 64'($unsigned(STAT_MAX)), 64'h0064);

        // Zero-length job.
        wr_snap = wr_cnt;
        @(posedge CLK) #1;
        START = 1'b1; LENGTH = 16'd0;
        @(negedge CLK);
        check_val("len0_done_early", 64'(DONE), 64'd0);
        @(posedge CLK) #1 START = 1'b0;
        @(negedge CLK);
        check_val("len0_done", 64'(DONE), 64'd1);
        check_val("len0_busy", 64'(BUSY), 64'd0);
        repeat (4) @(negedge CLK);
        check_val("len0_no_write", 64'(wr_cnt), 64'(wr_snap));

        // Soft reset mid-job after 5 bytes.
        fill(2);
        @(posedge CLK) #1;
        START = 1'b1; BASE_ADDR = 16'h0600; LENGTH = 16'd8;
        @(posedge CLK) #1 START = 1'b0;
        begin
            wr_t e;
            e.addr = 16'h0600;
            e.data = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};
            e.be   = 4'hF;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK) #1;
            IN_EN = 1'b1; IN_DATA = b_arr[i]; RMAX_IN = mx_arr[i]; RMIN_IN = mn_arr[i];
        end
        @(posedge CLK) #1;
        IN_EN = 1'b0; SOFT_RESET = 1'b1;
        done_snap = done_cnt;
        @(negedge CLK);
        check_val("srst_busy",     64'(BUSY), 64'd0);
        check_val("srst_wr_en",    64'(WR_EN), 64'd0);
        check_val("srst_byte_cnt", 64'(BYTE_CNT), 64'd0);
        check_val("srst_first_word_written", 64'(exp_q.size()), 64'd0);
        @(posedge CLK) #1 SOFT_RESET = 1'b0;
        repeat (10) @(negedge CLK);
        check_val("srst_no_done", 64'(done_cnt), 64'(done_snap));

        // Clean run after soft reset.
        fill(0);
        send_job(16'h0080, 16'd4);
        wait_done(100);
        job_end_checks(16'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
